// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port seen by
// dmem_arbiter. The arbiter connects through the slave modport; the
// requesters and the memory model connect through the master modport.
interface dmem_arbiter_if #(
    parameter int DW = 32
);
    logic          a_req;
    logic          a_we;
    logic [31:0]   a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;
    logic          a_err;

    logic          b_req;
    logic          b_we;
    logic [31:0]   b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;
    logic          b_err;

    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata, a_err,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata, b_err,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata, a_err,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata, b_err,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory.
// Port A has fixed priority; B is forced through after MAX_WAIT
// consecutive losses. Optional performance counters are built when
// DMEM_ARB_PERF_EN is defined.
//
// state  | meaning
// PRIO_A | A wins a conflict (default)
// PRIO_B | B has waited MAX_WAIT cycles and wins the next conflict
module dmem_arbiter #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic               clock,
    input  logic               reset,
    dmem_arbiter_if.slave      bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_a_grants,
    output logic [31:0]        perf_b_grants,
    output logic [31:0]        perf_conflicts,
    output logic               perf_clr
`endif
);

    typedef enum logic {PRIO_A, PRIO_B} state_t;

    localparam logic [3:0]  WAIT_SAT  = 4'(MAX_WAIT);
    localparam logic [3:0]  WAIT_LAST = 4'(MAX_WAIT - 1);
    localparam logic [31:0] ADDR_LIM  = 32'(DEPTH);

    state_t        state, state_nxt;
    logic [3:0]    wait_cnt, wait_nxt;
    logic          gnt_a, gnt_b, gnt_any;
    logic [31:0]   sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_we;
    logic          sel_oob;
    logic          sel_wp;

    // Grant selection, starvation tracking and next-state decode.
    always_comb begin
        state_nxt = state;
        wait_nxt  = 4'd0;
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        if (!reset) begin
            if (state == PRIO_B) begin
                if (bus.b_req)      gnt_b = 1'b1;
                else if (bus.a_req) gnt_a = 1'b1;
            end else begin
                if (bus.a_req)      gnt_a = 1'b1;
                else if (bus.b_req) gnt_b = 1'b1;
            end
        end
        if (bus.b_req && !gnt_b)
            wait_nxt = (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + 4'd1;
        case (state)
            PRIO_A: if (bus.b_req && !gnt_b && wait_cnt == WAIT_LAST) state_nxt = PRIO_B;
            PRIO_B: if (gnt_b || !bus.b_req) state_nxt = PRIO_A;
            default: state_nxt = PRIO_A;
        endcase
    end

    // State and starvation counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= PRIO_A;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Route the granted port onto the memory; illegal accesses never reach it.
    always_comb begin
        gnt_any   = gnt_a | gnt_b;
        sel_addr  = gnt_a ? bus.a_addr  : bus.b_addr;
        sel_wdata = gnt_a ? bus.a_wdata : bus.b_wdata;
        sel_we    = gnt_a ? bus.a_we    : bus.b_we;
        sel_oob   = sel_addr >= ADDR_LIM;
        sel_wp    = sel_we && (sel_addr == 32'd0);
        bus.a_gnt     = gnt_a;
        bus.b_gnt     = gnt_b;
        bus.mem_addr  = gnt_any ? sel_addr  : 32'd0;
        bus.mem_wdata = gnt_any ? sel_wdata : '0;
        bus.mem_we    = gnt_any && sel_we && !sel_oob && !sel_wp;
        bus.mem_re    = gnt_any && !sel_we && !sel_oob;
    end

    // Registered one-cycle response on the port that was granted.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.a_rvalid <= 1'b0;
            bus.a_rdata  <= '0;
            bus.a_err    <= 1'b0;
            bus.b_rvalid <= 1'b0;
            bus.b_rdata  <= '0;
            bus.b_err    <= 1'b0;
        end else begin
            bus.a_rvalid <= gnt_a;
            bus.b_rvalid <= gnt_b;
            bus.a_err    <= gnt_a && (sel_oob || sel_wp);
            bus.b_err    <= gnt_b && (sel_oob || sel_wp);
            if (gnt_a) bus.a_rdata <= bus.mem_re ? bus.mem_rdata : '0;
            if (gnt_b) bus.b_rdata <= bus.mem_re ? bus.mem_rdata : '0;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // Saturating grant/conflict counters; perf_clr pulses as one saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_a_grants  <= 32'd0;
            perf_b_grants  <= 32'd0;
            perf_conflicts <= 32'd0;
            perf_clr       <= 1'b0;
        end else begin
            if (gnt_a && perf_a_grants != 32'hFFFF_FFFF)
                perf_a_grants <= perf_a_grants + 32'd1;
            if (gnt_b && perf_b_grants != 32'hFFFF_FFFF)
                perf_b_grants <= perf_b_grants + 32'd1;
            if (bus.a_req && bus.b_req && perf_conflicts != 32'hFFFF_FFFF)
                perf_conflicts <= perf_conflicts + 32'd1;
            perf_clr <= (gnt_a && perf_a_grants == 32'hFFFF_FFFE)
                     || (gnt_b && perf_b_grants == 32'hFFFF_FFFE)
                     || (bus.a_req && bus.b_req && perf_conflicts == 32'hFFFF_FFFE);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases followed by random
// traffic, all compared against a transaction-level reference model.
module tb_dmem_arbiter;
    localparam int DW       = 32;
    localparam int DEPTH    = 32;
    localparam int MAX_WAIT = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.DW(DW)) bus ();

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_a_grants, perf_b_grants, perf_conflicts;
    logic        perf_clr;
`endif

    dmem_arbiter #(.DW(DW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_a_grants  (perf_a_grants),
        .perf_b_grants  (perf_b_grants),
        .perf_conflicts (perf_conflicts),
        .perf_clr       (perf_clr)
`endif
    );

    // memory environment: cleared while reset is high, combinational read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = (bus.mem_addr < DEPTH) ? mem[bus.mem_addr[4:0]] : '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // stimulus for the next cycle
    logic        rst, ar, aw, br, bw;
    logic [31:0] aa, ad, ba, bd;

    // reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int            losses = 0;
    logic [DW-1:0] exp_a_rdata = '0, exp_b_rdata = '0;
    logic          last_ga = 1'b0, last_gb = 1'b0;
    logic          dut_gb  = 1'b0;
    longint        m_pa = 0, m_pb = 0, m_pc = 0;

    task automatic step();
        logic        ga, gb, g, sw, oob, ev_a, ev_b, ee_a, ee_b;
        logic [31:0] sa, sd;
        @(negedge clock);
        reset       = rst;
        bus.a_req   = ar;  bus.a_we = aw;  bus.a_addr = aa;  bus.a_wdata = ad;
        bus.b_req   = br;  bus.b_we = bw;  bus.b_addr = ba;  bus.b_wdata = bd;
        #1;
        // B wins when alone, or once it has lost MAX_WAIT cycles in a row
        gb = !rst && br && (!ar || losses >= MAX_WAIT);
        ga = !rst && ar && !gb;
        g  = ga || gb;
        sa = ga ? aa : (gb ? ba : 32'd0);
        sd = ga ? ad : (gb ? bd : 32'd0);
        sw = ga ? aw : (gb ? bw : 1'b0);
        oob = sa >= DEPTH;
        chk_eq("a_gnt",     bus.a_gnt,     ga);
        chk_eq("b_gnt",     bus.b_gnt,     gb);
        chk_eq("mem_addr",  bus.mem_addr,  g ? sa : 32'd0);
        chk_eq("mem_wdata", bus.mem_wdata, g ? sd : 32'd0);
        chk_eq("mem_we",    bus.mem_we,    g && sw && !oob && sa != 0);
        chk_eq("mem_re",    bus.mem_re,    g && !sw && !oob);
        dut_gb = bus.b_gnt;

        ev_a = ga; ev_b = gb;
        ee_a = ga && (oob || (sw && sa == 0));
        ee_b = gb && (oob || (sw && sa == 0));
        if (rst) begin
            exp_a_rdata = '0; exp_b_rdata = '0;
        end else begin
            if (ga) exp_a_rdata = (!sw && !oob) ? ref_mem[sa] : '0;
            if (gb) exp_b_rdata = (!sw && !oob) ? ref_mem[sa] : '0;
        end
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            losses = 0;
            m_pa = 0; m_pb = 0; m_pc = 0;
        end else begin
            if (g && sw && !oob && sa != 0) ref_mem[sa] = sd;
            losses = (br && !gb) ? losses + 1 : 0;
            if (ga) m_pa++;
            if (gb) m_pb++;
            if (ar && br) m_pc++;
        end
        last_ga = ga; last_gb = gb;

        @(posedge clock);
        #1;
        chk_eq("a_rvalid", bus.a_rvalid, ev_a);
        chk_eq("b_rvalid", bus.b_rvalid, ev_b);
        chk_eq("a_rdata",  bus.a_rdata,  exp_a_rdata);
        chk_eq("b_rdata",  bus.b_rdata,  exp_b_rdata);
        if (ev_a) chk_eq("a_err", bus.a_err, ee_a);
        if (ev_b) chk_eq("b_err", bus.b_err, ee_b);
`ifdef DMEM_ARB_PERF_EN
        chk_eq("perf_a", perf_a_grants,  m_pa[31:0]);
        chk_eq("perf_b", perf_b_grants,  m_pb[31:0]);
        chk_eq("perf_c", perf_conflicts, m_pc[31:0]);
        chk_eq("perf_clr", perf_clr, 1'b0);
`endif
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'd0;
        if (r == 1) return 32'($urandom_range(32, 40));
        if (r == 2) return $urandom;
        return 32'($urandom_range(0, 7));
    endfunction

    task automatic idle();
        rst = 1'b0; ar = 1'b0; br = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rst = 1'b1; ar = 1'b1; aw = 1'b0; aa = 32'd3; ad = 32'd0;
        br = 1'b1; bw = 1'b1; ba = 32'd4; bd = 32'h1234;
        reset = 1'b1;
        step(); step();
        chk_eq("rst_a_rdata", bus.a_rdata, 32'd0);

        // A write then read of address 5
        idle(); ar = 1'b1; aw = 1'b1; aa = 32'd5; ad = 32'hDEAD_BEEF;
        step();
        aw = 1'b0;
        step();
        chk_eq("a_read5", bus.a_rdata, 32'hDEAD_BEEF);
        idle(); step();
        chk_eq("a_hold5", bus.a_rdata, 32'hDEAD_BEEF);

        // continuous conflicts: pattern A,A,A,A,B repeating
        rst = 1'b1; step();
        idle(); ar = 1'b1; aw = 1'b0; aa = 32'd5; br = 1'b1; bw = 1'b0; ba = 32'd6;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_eq("pattern_b", dut_gb, (i % 5) == 4);
        end
`ifdef DMEM_ARB_PERF_EN
        chk_eq("perf_c10", perf_conflicts, 32'd10);
        chk_eq("perf_a8",  perf_a_grants,  32'd8);
        chk_eq("perf_b2",  perf_b_grants,  32'd2);
`endif

        // B write to protected address 0, A reads address 0
        idle(); br = 1'b1; bw = 1'b1; ba = 32'd0; bd = 32'hFFFF_0000;
        step();
        chk_eq("b_wp_err", bus.b_err, 1'b1);
        idle(); ar = 1'b1; aw = 1'b0; aa = 32'd0;
        step();
        chk_eq("a_rd0_err",  bus.a_err,   1'b0);
        chk_eq("a_rd0_data", bus.a_rdata, 32'd0);

        // A reads past the end of memory
        aa = 32'd32;
        step();
        chk_eq("a_oob_err",  bus.a_err,   1'b1);
        chk_eq("a_oob_data", bus.a_rdata, 32'd0);

        // reset while conflict pending with two B losses
        idle(); ar = 1'b1; aw = 1'b0; aa = 32'd1; br = 1'b1; bw = 1'b0; ba = 32'd2;
        step(); step();
        rst = 1'b1; step();
        rst = 1'b0; step();
        chk_eq("post_rst_a", last_ga, 1'b1);

        // random traffic obeying the hold-until-grant rule
        idle();
        for (int c = 0; c < 3000; c++) begin
            if (!(ar && !last_ga)) begin
                ar = ($urandom_range(0, 99) < 60);
                aw = 1'($urandom_range(0, 1));
                aa = pick_addr();
                ad = $urandom;
            end
            if (!(br && !last_gb)) begin
                br = ($urandom_range(0, 99) < 60);
                bw = 1'($urandom_range(0, 1));
                ba = pick_addr();
                bd = $urandom;
            end
            rst = ($urandom_range(0, 299) == 0);
            if (rst) begin
                last_ga = 1'b0; last_gb = 1'b0;
            end
            step();
            if (rst) begin
                ar = 1'b0; br = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
